// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Parameter defaults of regfile_mp come from the *_DEF values below.
package regfile_mp_pkg;

  localparam int unsigned REG_W_DEF    = 32;
  localparam int unsigned REG_NUM_DEF  = 32;
  localparam int unsigned RD_PORTS_DEF = 2;
  localparam int unsigned WR_PORTS_DEF = 1;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_REG
  } rd_src_e;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One registered read lane: priority select between zero, forwarded write data
// and stored contents. Forwarding exists only when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
`ifdef REGFILE_MP_BYPASS_EN
  ,
  parameter int unsigned NUM_WR = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
`endif
  input  logic [DATA_W-1:0] rd_reg,
  output logic [DATA_W-1:0] rdata
);

  rd_src_e           src;
  logic [DATA_W-1:0] fwd;

  always_comb begin
    src = SRC_REG;
    fwd = '0;
    if (re != READ_ENABLE || raddr == '0) begin
      src = SRC_ZERO;
    end else begin
`ifdef REGFILE_MP_BYPASS_EN
      // ascending scan: the highest-index hitting port overrides, matching write priority
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
          src = SRC_BYPASS;
          fwd = wdata[k*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      case (src)
        SRC_ZERO:   rdata <= '0;
        SRC_BYPASS: rdata <= fwd;
        default:    rdata <= rd_reg;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file, r0 hardwired to zero, registered reads.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_W_DEF,
  parameter int unsigned NUM_REGS = REG_NUM_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = RD_PORTS_DEF,
  parameter int unsigned NUM_WR   = WR_PORTS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // later ports are applied last, so port NUM_WR-1 wins an address conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] != '0) begin
          regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[p*ADDR_W +: ADDR_W];

    regfile_mp_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
`ifdef REGFILE_MP_BYPASS_EN
      ,
      .NUM_WR (NUM_WR)
`endif
    ) u_rd (
      .clk    (clk),
      .rst    (rst),
      .re     (re[p]),
      .raddr  (ra),
`ifdef REGFILE_MP_BYPASS_EN
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
`endif
      .rd_reg (regs[ra]),
      .rdata  (rdata[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (4 read ports, 2 write ports).
// Expectations follow REGFILE_MP_BYPASS_EN when it is defined.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;
  localparam int unsigned NW = 2;

  logic             clk;
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;

  int unsigned total;
  int unsigned bad;

  regfile_mp #(
    .DATA_W   (DW),
    .NUM_REGS (32),
    .NUM_RD   (NR),
    .NUM_WR   (NW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int unsigned p);
    return rdata[p*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0;
  endtask

  task automatic wr(input int unsigned k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic rd(input int unsigned p, input logic en, input logic [AW-1:0] a);
    re[p] = en;
    raddr[p*AW +: AW] = a;
  endtask

  logic [DW-1:0] exp_v;

  initial begin
    total = 0;
    bad = 0;
    clr();
    rst = 1'b0;
    #12;
    for (int p = 0; p < NR; p++) check($sformatf("reset_lane%0d", p), lane(p), '0);
    rst = 1'b1;

    // reset clears storage and outputs asynchronously
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    clr();
    rd(0, 1'b1, 5'd5);
    tick();
    check("r5_written", lane(0), 32'hDEADBEEF);
    #2 rst = 1'b0;
    #1 check("rst_async", lane(0), '0);
    rst = 1'b1;
    tick();
    check("r5_after_rst", lane(0), '0);

    // basic write then read, disabled port returns zero
    clr();
    wr(0, 5'd3, 32'h12345678);
    tick();
    clr();
    rd(0, 1'b1, 5'd3);
    rd(1, 1'b0, 5'd3);
    tick();
    check("basic_rd0", lane(0), 32'h12345678);
    check("basic_rd1_off", lane(1), '0);

    // r0 ignores writes
    clr();
    wr(0, 5'd0, 32'hFFFFFFFF);
    tick();
    clr();
    for (int p = 0; p < NR; p++) rd(p, 1'b1, 5'd0);
    tick();
    for (int p = 0; p < NR; p++) check($sformatf("r0_lane%0d", p), lane(p), '0);

    // same-cycle read/write of r7
    clr();
    wr(0, 5'd7, 32'h1);
    tick();
    clr();
    wr(0, 5'd7, 32'h2);
    rd(0, 1'b1, 5'd7);
    tick();
`ifdef REGFILE_MP_BYPASS_EN
    exp_v = 32'h2;
`else
    exp_v = 32'h1;
`endif
    check("r7_same_cycle", lane(0), exp_v);
    clr();
    rd(0, 1'b1, 5'd7);
    tick();
    check("r7_next_cycle", lane(0), 32'h2);

    // dual-write conflict: port 1 wins
    clr();
    wr(0, 5'd9, 32'hAAAA0000);
    wr(1, 5'd9, 32'h5555FFFF);
    rd(1, 1'b1, 5'd9);
    tick();
`ifdef REGFILE_MP_BYPASS_EN
    exp_v = 32'h5555FFFF;
`else
    exp_v = '0;
`endif
    check("r9_same_cycle", lane(1), exp_v);
    clr();
    rd(1, 1'b1, 5'd9);
    tick();
    check("r9_conflict", lane(1), 32'h5555FFFF);

    // port independence
    clr();
    wr(0, 5'd1, 32'd1);
    wr(1, 5'd2, 32'd2);
    tick();
    clr();
    wr(0, 5'd3, 32'd3);
    wr(1, 5'd4, 32'd4);
    tick();
    clr();
    for (int p = 0; p < NR; p++) rd(p, 1'b1, AW'(p + 1));
    tick();
    for (int p = 0; p < NR; p++) check($sformatf("indep_lane%0d", p), lane(p), DW'(p + 1));
    re[2] = 1'b0;
    tick();
    for (int p = 0; p < NR; p++)
      check($sformatf("re2_off_lane%0d", p), lane(p), (p == 2) ? '0 : DW'(p + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
